// File: rtl/coin_machine_v2.sv
// coin_machine_v2: edge-detected coin accumulator that pulses a vend and keeps any excess as credit
module coin_machine_v2 #(
  parameter int unsigned PRICE = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  output logic       dispenseNoBalance,
  output logic       dispenseBalance,
  output logic [7:0] count
);
  localparam logic [8:0] P9 = 9'(PRICE);
  logic       prev_n, prev_d, prev_q;
  logic [5:0] coins;
  logic [8:0] sum, diff;
  logic [7:0] count_nx;
  logic       nb_nx, b_nx;
  // coin value this cycle from rising edges, then the next balance and vend decision
  always_comb begin
    coins = (nickel && !prev_n ? 6'd5 : 6'd0) + (dime && !prev_d ? 6'd10 : 6'd0) +
            (quarter && !prev_q ? 6'd25 : 6'd0);
    sum = {1'b0, count} + {3'b0, coins};
    diff = sum - P9;
    count_nx = coins == 6'd0 ? count : sum < P9 ? sum[7:0] : sum == P9 ? 8'd0 : diff[7:0];
    nb_nx = coins != 6'd0 && sum == P9;
    b_nx = coins != 6'd0 && sum > P9;
  end
  // previous-value registers always track the inputs so a coin held through reset is not counted
  always_ff @(posedge clk) begin
    prev_n <= nickel;
    prev_d <= dime;
    prev_q <= quarter;
    if (rst) begin
      count <= 8'd0;
      dispenseNoBalance <= 1'b0;
      dispenseBalance <= 1'b0;
    end else begin
      count <= count_nx;
      dispenseNoBalance <= nb_nx;
      dispenseBalance <= b_nx;
    end
  end
endmodule

// File: tb/tb_coin_machine_v2.sv
// tb_coin_machine_v2: scoreboard bench for the coin accumulator with PRICE = 30
module tb_coin_machine_v2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic nickel = 1'b0, dime = 1'b0, quarter = 1'b0;
  logic dispenseNoBalance, dispenseBalance;
  logic [7:0] count;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic n, d, q, r;
    logic [7:0] c;
    logic nb, b;
  } step_t;

  step_t sb[$];

  coin_machine_v2 #(.PRICE(30)) dut (
    .clk(clk),
    .rst(rst),
    .nickel(nickel),
    .dime(dime),
    .quarter(quarter),
    .dispenseNoBalance(dispenseNoBalance),
    .dispenseBalance(dispenseBalance),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic step_t st(input logic n, d, q, r, input logic [7:0] c, input logic nb, b);
    st = '{n: n, d: d, q: q, r: r, c: c, nb: nb, b: b};
  endfunction

  task automatic tick(input step_t s);
    @(negedge clk);
    nickel = s.n;
    dime = s.d;
    quarter = s.q;
    rst = s.r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step_t s[6];
    step_t e;
    s = '{st(0,0,0,1,0,0,0), st(0,0,0,1,0,0,0), st(1,0,0,1,0,0,0),
          st(1,0,0,0,0,0,0), st(1,0,0,0,0,0,0), st(0,0,0,0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(s[i]);
      tick(s[i]);
      e = sb.pop_front();
      checks++;
      if ({count, dispenseNoBalance, dispenseBalance} !== {e.c, e.nb, e.b}) begin
        failures++;
        $display("FAIL reset[%0d]: got count=%0d nb=%b b=%b, expected count=%0d nb=%b b=%b",
                 i, count, dispenseNoBalance, dispenseBalance, e.c, e.nb, e.b);
      end
    end
  endtask

  task automatic test_accumulate;
    step_t s[15];
    step_t e;
    s = '{st(1,0,0,0,5,0,0), st(0,0,0,0,5,0,0), st(0,1,0,0,15,0,0), st(0,0,0,0,15,0,0),
          st(0,0,1,0,10,0,1), st(0,0,0,0,10,0,0),
          st(0,1,0,0,20,0,0), st(0,0,0,0,20,0,0), st(0,0,1,0,15,0,1), st(0,0,0,0,15,0,0),
          st(0,1,0,0,25,0,0), st(0,0,0,0,25,0,0), st(0,0,1,0,20,0,1), st(0,0,0,0,20,0,0),
          st(0,0,0,0,20,0,0)};
    for (int i = 0; i < 15; i++) begin
      sb.push_back(s[i]);
      tick(s[i]);
      e = sb.pop_front();
      checks++;
      if ({count, dispenseNoBalance, dispenseBalance} !== {e.c, e.nb, e.b}) begin
        failures++;
        $display("FAIL accumulate[%0d]: got count=%0d nb=%b b=%b, expected count=%0d nb=%b b=%b",
                 i, count, dispenseNoBalance, dispenseBalance, e.c, e.nb, e.b);
      end
    end
  endtask

  task automatic test_exact_and_hold;
    step_t s[14];
    step_t e;
    s = '{st(0,1,0,0,0,1,0), st(0,1,0,0,0,0,0), st(0,1,0,0,0,0,0), st(0,1,0,0,0,0,0),
          st(0,1,0,0,0,0,0), st(0,1,0,0,0,0,0), st(0,1,0,0,0,0,0), st(0,1,0,0,0,0,0),
          st(0,1,0,0,0,0,0), st(0,1,0,0,0,0,0), st(0,0,0,0,0,0,0), st(0,1,0,0,10,0,0),
          st(0,1,0,0,10,0,0), st(0,0,0,0,10,0,0)};
    for (int i = 0; i < 14; i++) begin
      sb.push_back(s[i]);
      tick(s[i]);
      e = sb.pop_front();
      checks++;
      if ({count, dispenseNoBalance, dispenseBalance} !== {e.c, e.nb, e.b}) begin
        failures++;
        $display("FAIL exact_hold[%0d]: got count=%0d nb=%b b=%b, expected count=%0d nb=%b b=%b",
                 i, count, dispenseNoBalance, dispenseBalance, e.c, e.nb, e.b);
      end
    end
  endtask

  task automatic test_simultaneous;
    step_t s[6];
    step_t e;
    s = '{st(0,1,0,0,20,0,0), st(0,0,0,0,20,0,0), st(0,1,0,0,0,1,0), st(0,0,0,0,0,0,0),
          st(1,1,1,0,10,0,1), st(0,0,0,0,10,0,0)};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(s[i]);
      tick(s[i]);
      e = sb.pop_front();
      checks++;
      if ({count, dispenseNoBalance, dispenseBalance} !== {e.c, e.nb, e.b}) begin
        failures++;
        $display("FAIL simultaneous[%0d]: got count=%0d nb=%b b=%b, expected count=%0d nb=%b b=%b",
                 i, count, dispenseNoBalance, dispenseBalance, e.c, e.nb, e.b);
      end
    end
  endtask

  task automatic test_reset_midway;
    step_t s[5];
    step_t e;
    s = '{st(0,1,0,0,20,0,0), st(0,0,0,0,20,0,0), st(0,1,0,1,0,0,0), st(0,1,0,0,0,0,0),
          st(0,0,0,0,0,0,0)};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(s[i]);
      tick(s[i]);
      e = sb.pop_front();
      checks++;
      if ({count, dispenseNoBalance, dispenseBalance} !== {e.c, e.nb, e.b}) begin
        failures++;
        $display("FAIL reset_midway[%0d]: got count=%0d nb=%b b=%b, expected count=%0d nb=%b b=%b",
                 i, count, dispenseNoBalance, dispenseBalance, e.c, e.nb, e.b);
      end
    end
  endtask

  task automatic test_back_to_back;
    step_t s[7];
    step_t e;
    s = '{st(1,0,0,0,5,0,0), st(0,1,0,0,15,0,0), st(1,0,0,0,20,0,0), st(0,1,0,0,0,1,0),
          st(0,0,1,0,25,0,0), st(1,0,0,0,0,1,0), st(0,0,0,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(s[i]);
      tick(s[i]);
      e = sb.pop_front();
      checks++;
      if ({count, dispenseNoBalance, dispenseBalance} !== {e.c, e.nb, e.b}) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got count=%0d nb=%b b=%b, expected count=%0d nb=%b b=%b",
                 i, count, dispenseNoBalance, dispenseBalance, e.c, e.nb, e.b);
      end
    end
  endtask

  initial begin
    test_reset;
    test_accumulate;
    test_exact_and_hold;
    test_simultaneous;
    test_reset_midway;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
